// File: rtl/wb_pkg.sv
// Shared widths and the write-back entry type for the write-back stage.
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Show-ahead FIFO: the head entry is readable combinationally while non-empty.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end
endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: arbitrates ALU results against buffered load responses
// for the single register file write port and tracks pending load targets.
module writeback_unit #(
    parameter int XLEN      = wb_pkg::XLEN,
    parameter int MAX_LOADS = 4,
    parameter int RES_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue_valid,
    input  logic [4:0]      ld_issue_rd,
    input  logic            ld_resp_valid,
    output logic            ld_resp_ready,
    input  logic [XLEN-1:0] ld_resp_data,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            hazard,
    output logic            issue_full,
    output logic            wb_stall,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            proto_err
);
    import wb_pkg::*;

    localparam int ENT_W = REG_ADDR_W + XLEN;

    logic                          tag_push, tag_pop, tag_full, tag_empty;
    logic [REG_ADDR_W-1:0]         tag_head;
    logic [$clog2(MAX_LOADS):0]    tag_count;
    logic                          res_push, res_pop, res_full, res_empty;
    logic [ENT_W-1:0]              res_din, res_dout;
    logic [$clog2(RES_DEPTH):0]    res_count;
    logic                          resp_acc;
    logic [REG_ADDR_W-1:0]         head_rd;
    logic [XLEN-1:0]               head_data;

    logic                          wb_en_q, wb_en_d;
    logic [REG_ADDR_W-1:0]         wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]               wb_data_q, wb_data_d;
    logic                          proto_err_q, proto_err_d;
    logic [31:1]                   busy_q, busy_d;
    logic [31:0]                   busy_vec;
    logic                          unused_counts;

    assign issue_full    = tag_full;
    assign wb_stall      = res_full;
    assign ld_resp_ready = !res_full;
    assign unused_counts = ^{tag_count, res_count};

    assign tag_push  = ld_issue_valid && !tag_full;
    assign resp_acc  = ld_resp_valid && !res_full;
    assign tag_pop   = resp_acc && !tag_empty;
    assign res_push  = tag_pop;
    assign res_din   = {tag_head, ld_resp_data};
    assign res_pop   = !alu_valid && !res_empty;
    assign head_rd   = res_dout[ENT_W-1 -: REG_ADDR_W];
    assign head_data = res_dout[XLEN-1:0];

    wb_fifo #(.WIDTH(REG_ADDR_W), .DEPTH(MAX_LOADS)) u_tag_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (ld_issue_rd),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    wb_fifo #(.WIDTH(ENT_W), .DEPTH(RES_DEPTH)) u_res_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (res_push),
        .pop   (res_pop),
        .din   (res_din),
        .dout  (res_dout),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    always_comb begin
        wb_en_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        proto_err_d = proto_err_q | (resp_acc && tag_empty);
        if (alu_valid) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = alu_rd;
            wb_data_d = alu_data;
        end else if (res_pop) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = head_rd;
            wb_data_d = head_data;
        end
    end

    // A new issue to a register outranks the retirement of an older load to it.
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
        assign busy_d[gi] = (tag_push && (ld_issue_rd == 5'(gi))) |
                            (busy_q[gi] & ~(res_pop && (head_rd == 5'(gi))));
    end

    assign busy_vec = {busy_q, 1'b0};
    assign hazard   = busy_vec[chk_rs1] | busy_vec[chk_rs2] | busy_vec[chk_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            proto_err_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            proto_err_q <= proto_err_d;
            busy_q      <= busy_d;
        end
    end

    assign wb_en     = wb_en_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: vector table, directed corner sequences and a
// constrained random phase, all checked against a behavioural scoreboard.
module tb_writeback_unit;
    import wb_pkg::*;

    localparam int ML = 4;
    localparam int RD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_issue_valid = 1'b0;
    logic [4:0]  ld_issue_rd = '0;
    logic        ld_resp_valid = 1'b0;
    logic        ld_resp_ready;
    logic [31:0] ld_resp_data = '0;
    logic [4:0]  chk_rs1 = '0;
    logic [4:0]  chk_rs2 = '0;
    logic [4:0]  chk_rd = '0;
    logic        hazard, issue_full, wb_stall, wb_en, proto_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    writeback_unit #(.XLEN(32), .MAX_LOADS(ML), .RES_DEPTH(RD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_ready  (ld_resp_ready),
        .ld_resp_data   (ld_resp_data),
        .chk_rs1        (chk_rs1),
        .chk_rs2        (chk_rs2),
        .chk_rd         (chk_rd),
        .hazard         (hazard),
        .issue_full     (issue_full),
        .wb_stall       (wb_stall),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model state: pending tags and accepted-but-unwritten loads.
    wb_entry_t   exp_ld[$];
    logic [4:0]  tags[$];
    logic [31:0] m_busy;
    logic        m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_proto;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        iv;
        logic [4:0]  ird;
        logic        rv;
        logic [31:0] rdat;
        logic [4:0]  c1;
        logic        e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_haz;
        logic        e_stall;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_ld.delete();
        tags.delete();
        m_busy  = '0;
        m_en    = 1'b0;
        m_rd    = '0;
        m_data  = '0;
        m_proto = 1'b0;
    endtask

    task automatic clear_inputs();
        alu_valid      = 1'b0;
        ld_issue_valid = 1'b0;
        ld_resp_valid  = 1'b0;
        chk_rs1        = '0;
        chk_rs2        = '0;
        chk_rd         = '0;
    endtask

    function automatic logic m_haz();
        return m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd];
    endfunction

    // Advance the model with the current inputs, clock once, compare outputs.
    task automatic cycle();
        int        buf_n;
        int        tag_n;
        wb_entry_t e;
        logic [4:0] r;
        buf_n = exp_ld.size();
        tag_n = tags.size();
        if (alu_valid) begin
            m_en = 1'b1; m_rd = alu_rd; m_data = alu_data;
        end else if (buf_n > 0) begin
            e = exp_ld.pop_front();
            m_en = 1'b1; m_rd = e.rd; m_data = e.data;
            m_busy[e.rd] = 1'b0;
        end else begin
            m_en = 1'b0;
        end
        if (ld_resp_valid && buf_n < RD) begin
            if (tag_n > 0) begin
                r = tags.pop_front();
                exp_ld.push_back('{rd: r, data: ld_resp_data});
            end else begin
                m_proto = 1'b1;
            end
        end
        if (ld_issue_valid && tag_n < ML) begin
            tags.push_back(ld_issue_rd);
            if (ld_issue_rd != 5'd0) m_busy[ld_issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("wb_en", {63'd0, wb_en}, {63'd0, m_en});
        if (m_en) begin
            chk("wb_rd", {59'd0, wb_rd}, {59'd0, m_rd});
            chk("wb_data", {32'd0, wb_data}, {32'd0, m_data});
        end
        chk("ld_resp_ready", {63'd0, ld_resp_ready}, {63'd0, exp_ld.size() < RD});
        chk("wb_stall", {63'd0, wb_stall}, {63'd0, exp_ld.size() == RD});
        chk("issue_full", {63'd0, issue_full}, {63'd0, tags.size() == ML});
        chk("proto_err", {63'd0, proto_err}, {63'd0, m_proto});
        chk("hazard", {63'd0, hazard}, {63'd0, m_haz()});
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
        chk("rst_wb_data", {32'd0, wb_data}, 64'd0);
        chk("rst_proto_err", {63'd0, proto_err}, 64'd0);
        chk("rst_issue_full", {63'd0, issue_full}, 64'd0);
        chk("rst_wb_stall", {63'd0, wb_stall}, 64'd0);
        chk("rst_ld_resp_ready", {63'd0, ld_resp_ready}, 64'd1);
        for (int r = 0; r < 32; r++) begin
            chk_rs1 = 5'(r);
            #0.1;
            chk("rst_hazard", {63'd0, hazard}, 64'd0);
        end
        chk_rs1 = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] adat,
                                logic iv, logic [4:0] ird, logic rv, logic [31:0] rdat,
                                logic [4:0] c1, logic e_en, logic [4:0] e_rd,
                                logic [31:0] e_data, logic e_haz, logic e_stall);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat; v.iv = iv; v.ird = ird;
        v.rv = rv; v.rdat = rdat; v.c1 = c1; v.e_en = e_en; v.e_rd = e_rd;
        v.e_data = e_data; v.e_haz = e_haz; v.e_stall = e_stall;
        return v;
    endfunction

    initial begin
        model_reset();
        #1;
        do_reset();

        // ALU pass, single load with hazard, ALU/load contention filling the result FIFO.
        tbl[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 32'h0,    5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  1'b0, 32'h0,    5'd7,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0);
        tbl[2]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,    5'd7,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b1, 32'h1234, 5'd7,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,    5'd7,  1'b1, 5'd7,  32'h1234,     1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd9,  1'b0, 32'h0,    5'd9,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 1'b0, 32'h0,    5'd10, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0);
        tbl[7]  = mk(1'b1, 5'd3, 32'h33,       1'b0, 5'd0,  1'b1, 32'hA9,   5'd9,  1'b1, 5'd3,  32'h33,       1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 5'd3, 32'h34,       1'b0, 5'd0,  1'b1, 32'hAA,   5'd9,  1'b1, 5'd3,  32'h34,       1'b1, 1'b1);
        tbl[9]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,    5'd9,  1'b1, 5'd9,  32'hA9,       1'b0, 1'b0);
        tbl[10] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,    5'd10, 1'b1, 5'd10, 32'hAA,       1'b0, 1'b0);
        tbl[11] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,    5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            alu_valid      = tbl[i].av;
            alu_rd         = tbl[i].ard;
            alu_data       = tbl[i].adat;
            ld_issue_valid = tbl[i].iv;
            ld_issue_rd    = tbl[i].ird;
            ld_resp_valid  = tbl[i].rv;
            ld_resp_data   = tbl[i].rdat;
            chk_rs1        = tbl[i].c1;
            cycle();
            chk("tbl_wb_en", {63'd0, wb_en}, {63'd0, tbl[i].e_en});
            if (tbl[i].e_en) begin
                chk("tbl_wb_rd", {59'd0, wb_rd}, {59'd0, tbl[i].e_rd});
                chk("tbl_wb_data", {32'd0, wb_data}, {32'd0, tbl[i].e_data});
            end
            chk("tbl_hazard", {63'd0, hazard}, {63'd0, tbl[i].e_haz});
            chk("tbl_wb_stall", {63'd0, wb_stall}, {63'd0, tbl[i].e_stall});
            $display("vec %0d: wb_en=%0d wb_rd=%0d wb_data=0x%0h hazard=%0d stall=%0d",
                     i, wb_en, wb_rd, wb_data, hazard, wb_stall);
        end
        clear_inputs();

        // Fill the tag queue, try a fifth issue, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            ld_issue_valid = 1'b1;
            ld_issue_rd    = 5'(i);
            chk_rs1        = 5'(i);
            cycle();
        end
        chk("issue_full_after4", {63'd0, issue_full}, 64'd1);
        ld_issue_rd = 5'd5;
        chk_rs1     = 5'd5;
        cycle();
        chk("fifth_issue_ignored", {63'd0, hazard}, 64'd0);
        ld_issue_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ld_resp_valid = 1'b1;
            ld_resp_data  = 32'h100 + 32'(i);
            chk_rs1       = 5'(i);
            cycle();
            if (i >= 2) begin
                chk("order_rd", {59'd0, wb_rd}, 64'(i - 1));
            end
            $display("drain %0d: wb_en=%0d wb_rd=%0d issue_full=%0d", i, wb_en, wb_rd, issue_full);
        end
        ld_resp_valid = 1'b0;
        chk_rs1 = 5'd4;
        cycle();
        chk("order_last_rd", {59'd0, wb_rd}, 64'd4);
        chk("busy4_cleared", {63'd0, hazard}, 64'd0);

        // Response with nothing pending.
        clear_inputs();
        ld_resp_valid = 1'b1;
        ld_resp_data  = 32'h55;
        cycle();
        chk("proto_set", {63'd0, proto_err}, 64'd1);
        ld_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("proto_sticky", {63'd0, proto_err}, 64'd1);
        $display("proto: proto_err=%0d wb_en=%0d", proto_err, wb_en);
        do_reset();

        // Reset with two loads pending and one result buffered.
        for (int i = 11; i <= 13; i++) begin
            ld_issue_valid = 1'b1;
            ld_issue_rd    = 5'(i);
            cycle();
        end
        ld_issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020;
        ld_resp_valid = 1'b1; ld_resp_data = 32'h77;
        cycle();
        ld_resp_valid = 1'b0;
        alu_rd = 5'd21; alu_data = 32'h2121;
        chk_rs1 = 5'd11; chk_rs2 = 5'd12; chk_rd = 5'd13;
        cycle();
        chk("pre_reset_hazard", {63'd0, hazard}, 64'd1);
        do_reset();
        for (int i = 0; i < 2; i++) cycle();
        ld_resp_valid = 1'b1; ld_resp_data = 32'h88;
        cycle();
        ld_resp_valid = 1'b0;
        chk("post_reset_tags_gone", {63'd0, proto_err}, 64'd1);
        $display("reset: proto_err=%0d wb_en=%0d", proto_err, wb_en);
        do_reset();

        // Constrained random traffic.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] r;
            alu_valid = (exp_ld.size() < RD) && ($urandom_range(0, 2) == 0);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            r = 5'($urandom_range(0, 31));
            ld_issue_valid = ($urandom_range(0, 2) == 0) && !m_busy[r];
            ld_issue_rd    = r;
            ld_resp_valid  = (tags.size() > 0) && ($urandom_range(0, 1) == 1);
            ld_resp_data   = $urandom;
            chk_rs1 = 5'($urandom_range(0, 31));
            chk_rs2 = 5'($urandom_range(0, 31));
            chk_rd  = 5'($urandom_range(0, 31));
            cycle();
        end
        clear_inputs();
        for (int i = 0; i < 4; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
